cordic_sincos_iter: RTL and testbench

//  Parametrised iterative CORDIC (rotation mode): one micro-rotation per clock; returns cos and sin of a signed angle.

---
 rtl/cordic_sincos_iter_if.sv | 54 +++++
 rtl/cordic_sincos_iter.sv | 208 ++++++++++++++++++++
 tb/tb_cordic_sincos_iter.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_sincos_iter_if.sv
// ----------------------------------------------------------------------------
// cordic_sincos_iter_if
//
// Handshake bundle for the iterative CORDIC sin/cos unit. An angle is offered
// on the input side with in_valid/in_ready and the cos/sin result comes back
// with out_valid/out_ready. All data fields are signed Q3.(WIDTH-3).
//
// Parameters:
//   WIDTH      data width of angle, cos_out and sin_out
//
// Signals:
//   in_valid   angle offered by the source
//   in_ready   CORDIC accepts the angle this cycle
//   angle      radians, Q3.(WIDTH-3)
//   out_valid  cos_out/sin_out hold a result
//   out_ready  downstream accepts the result
//   cos_out    cos(angle), Q3.(WIDTH-3)
//   sin_out    sin(angle), Q3.(WIDTH-3)
//
// Modports:
//   master     angle source / result sink (drives in_valid, angle, out_ready)
//   slave      the CORDIC unit itself
// ----------------------------------------------------------------------------
interface cordic_sincos_iter_if #(
   parameter int WIDTH = 22
);
   logic                    in_valid;
   logic                    in_ready;
   logic signed [WIDTH-1:0] angle;
   logic                    out_valid;
   logic                    out_ready;
   logic signed [WIDTH-1:0] cos_out;
   logic signed [WIDTH-1:0] sin_out;

   modport master (
      output in_valid,
      output angle,
      output out_ready,
      input  in_ready,
      input  out_valid,
      input  cos_out,
      input  sin_out
   );

   modport slave (
      input  in_valid,
      input  angle,
      input  out_ready,
      output in_ready,
      output out_valid,
      output cos_out,
      output sin_out
   );
endinterface

// File: rtl/cordic_sincos_iter.sv
// ----------------------------------------------------------------------------
// cordic_sincos_iter
//
// Iterative rotation-mode CORDIC producing cos and sin of a signed angle.
// One micro-rotation is performed per clock; a result is available ITER+1
// clocks after the angle is accepted (counting the accepting edge). Sits
// between the angle generator and the FP pack stage of the trig datapath.
//
// Parameters:
//   WIDTH  data width, all values signed Q3.(WIDTH-3); legal 16..32
//   ITER   micro-rotations per operation; legal 8..WIDTH-4 (max 28)
//
// Ports:
//   clk      rising-edge clock
//   reset_n  asynchronous, active-low reset
//   io       cordic_sincos_iter_if.slave (in_valid/in_ready/angle,
//            out_valid/out_ready/cos_out/sin_out)
//
// Configuration macro:
//   QUAD_EXT_EN  when defined the input range extends to +/-pi: angles beyond
//                +/-pi/2 are folded by pi at load time and both results are
//                negated on completion. When undefined there is no folding
//                and |angle| > pi/2 yields meaningless values (timing and
//                handshake are unchanged).
// ----------------------------------------------------------------------------
module cordic_sincos_iter #(
   parameter int WIDTH = 22,
   parameter int ITER  = 16
) (
   input logic                clk,
   input logic                reset_n,
   cordic_sincos_iter_if.slave io
);

   localparam int FRAC  = WIDTH - 3;
   localparam int SHIFT = 30 - FRAC;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   // Arctangent table in Q2.30: atan(2^-idx) * 2^30, rounded. From idx = 10
   // onwards atan(2^-idx) rounds to exactly 2^(30-idx) at this precision.
   function automatic logic [31:0] atanQ30(input logic [4:0] idx);
      logic [31:0] value;
      case (idx)
         5'd0:    value = 32'h3243F6A9;
         5'd1:    value = 32'h1DAC6705;
         5'd2:    value = 32'h0FADBAFD;
         5'd3:    value = 32'h07F56EA7;
         5'd4:    value = 32'h03FEAB77;
         5'd5:    value = 32'h01FFD55C;
         5'd6:    value = 32'h00FFFAAB;
         5'd7:    value = 32'h007FFF55;
         5'd8:    value = 32'h003FFFEB;
         5'd9:    value = 32'h001FFFFD;
         default: value = (idx <= 5'd27) ? (32'd1 << (5'd30 - idx)) : 32'd0;
      endcase
      return value;
   endfunction

   // Converts a non-negative Q2.30 constant to Q3.FRAC with round-half-up.
   function automatic logic signed [WIDTH-1:0] scaleQ30(input logic [63:0] v);
      return WIDTH'((v + (64'd1 << (SHIFT - 1))) >> SHIFT);
   endfunction

   // CORDIC gain compensation: x starts at 1/An so the result needs no
   // post-scaling.
   localparam logic signed [WIDTH-1:0] K_INIT = scaleQ30(64'h26DD3B6A);

`ifdef QUAD_EXT_EN
   localparam logic signed [WIDTH-1:0] HALF_PI     = scaleQ30(64'h6487ED51);
   localparam logic signed [WIDTH-1:0] PI          = scaleQ30(64'hC90FDAA2);
   localparam logic signed [WIDTH-1:0] NEG_HALF_PI = -HALF_PI;
`endif

   state_t                  state_q;
   logic signed [WIDTH-1:0] x_q;
   logic signed [WIDTH-1:0] y_q;
   logic signed [WIDTH-1:0] z_q;
   logic [4:0]              i_q;
   logic                    flip_q;
   logic                    outValid_q;
   logic signed [WIDTH-1:0] cos_q;
   logic signed [WIDTH-1:0] sin_q;

   logic                    dir;
   logic signed [WIDTH-1:0] xShift;
   logic signed [WIDTH-1:0] yShift;
   logic signed [WIDTH-1:0] atanStep;
   logic signed [WIDTH-1:0] x_d;
   logic signed [WIDTH-1:0] y_d;
   logic signed [WIDTH-1:0] z_d;
   logic signed [WIDTH-1:0] zLoad;
   logic                    flipLoad;
   logic                    inReady;
   logic                    accept;
   logic                    lastStep;

   // The unit takes a new angle whenever it is idle, and also in the DONE
   // cycle that hands the result downstream, so back-to-back operations
   // run without an idle bubble. Held low while reset is asserted.
   assign inReady  = reset_n && ((state_q == IDLE) ||
                                 ((state_q == DONE) && io.out_ready));
   assign accept   = io.in_valid && inReady;
   assign lastStep = (i_q == 5'(ITER - 1));

   // One micro-rotation from the registered x/y/z. The direction is the sign
   // of the residual angle: a negative residual rotates back positive.
   always_comb begin
      dir      = z_q[WIDTH-1];
      xShift   = x_q >>> i_q;
      yShift   = y_q >>> i_q;
      atanStep = scaleQ30(64'(atanQ30(i_q)));
      x_d      = dir ? (x_q + yShift)   : (x_q - yShift);
      y_d      = dir ? (y_q - xShift)   : (y_q + xShift);
      z_d      = dir ? (z_q + atanStep) : (z_q - atanStep);
   end

   // Initial residual angle. With the quadrant extension, angles outside
   // +/-pi/2 are moved by pi into the convergence range; the flip flag
   // remembers to negate both results at the end since cos/sin(a-pi) = -cos/sin(a).
   always_comb begin
      zLoad    = io.angle;
      flipLoad = 1'b0;
`ifdef QUAD_EXT_EN
      if (io.angle > HALF_PI) begin
         zLoad    = io.angle - PI;
         flipLoad = 1'b1;
      end else if (io.angle < NEG_HALF_PI) begin
         zLoad    = io.angle + PI;
         flipLoad = 1'b1;
      end
`endif
   end

   // Control FSM and datapath registers. Results are copied into dedicated
   // output registers on the final step so that cos_out/sin_out stay stable
   // throughout DONE and across a following operation until the next result.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q    <= IDLE;
         x_q        <= '0;
         y_q        <= '0;
         z_q        <= '0;
         i_q        <= '0;
         flip_q     <= 1'b0;
         outValid_q <= 1'b0;
         cos_q      <= '0;
         sin_q      <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  x_q     <= K_INIT;
                  y_q     <= '0;
                  z_q     <= zLoad;
                  i_q     <= '0;
                  flip_q  <= flipLoad;
                  state_q <= RUN;
               end
            end

            RUN: begin
               x_q <= x_d;
               y_q <= y_d;
               z_q <= z_d;
               i_q <= i_q + 5'd1;
               if (lastStep) begin
                  cos_q      <= flip_q ? -x_d : x_d;
                  sin_q      <= flip_q ? -y_d : y_d;
                  outValid_q <= 1'b1;
                  state_q    <= DONE;
               end
            end

            DONE: begin
               if (io.out_ready) begin
                  outValid_q <= 1'b0;
                  if (accept) begin
                     x_q     <= K_INIT;
                     y_q     <= '0;
                     z_q     <= zLoad;
                     i_q     <= '0;
                     flip_q  <= flipLoad;
                     state_q <= RUN;
                  end else begin
                     state_q <= IDLE;
                  end
               end
            end

            default: begin
               state_q    <= IDLE;
               outValid_q <= 1'b0;
            end
         endcase
      end
   end

   assign io.in_ready  = inReady;
   assign io.out_valid = outValid_q;
   assign io.cos_out   = cos_q;
   assign io.sin_out   = sin_q;

endmodule

// File: tb/tb_cordic_sincos_iter.sv
// ----------------------------------------------------------------------------
// tb_cordic_sincos_iter
//
// Self-checking bench for cordic_sincos_iter at WIDTH=22, ITER=16 (Q3.19).
// Directed angles with hand-computed cos/sin, latency, backpressure,
// mid-operation reset, a back-to-back stream checked against $cos/$sin, and
// (when QUAD_EXT_EN is defined) angles beyond +/-pi/2.
// ----------------------------------------------------------------------------
module tb_cordic_sincos_iter;

   localparam int WIDTH = 22;
   localparam int ITER  = 16;
   localparam int LAT   = ITER + 1;
   localparam int TOL   = 16;
   // The final residual angle alone can approach 16 LSB; truncating shifts
   // add a few more, so the random stream gets some extra headroom.
   localparam int RTOL  = 32;
   localparam real SCALE = 524288.0;

   logic clk     = 1'b0;
   logic reset_n = 1'b0;

   int testsRun    = 0;
   int testsFailed = 0;

   cordic_sincos_iter_if #(.WIDTH(WIDTH)) io ();

   cordic_sincos_iter #(
      .WIDTH(WIDTH),
      .ITER (ITER)
   ) dut (
      .clk    (clk),
      .reset_n(reset_n),
      .io     (io.slave)
   );

   // Free-running 100 MHz clock.
   always #5 clk = ~clk;

   // Single comparison point: counts every check and reports any miss.
   task automatic checkOutput(input string tag, input int observed,
                              input int expected, input int tol);
      int diff;
      diff = observed - expected;
      testsRun++;
      if (diff > tol || diff < -tol) begin
         testsFailed++;
         $display("[TB] FAIL %s: observed %0d, expected %0d (tol %0d)",
                  tag, observed, expected, tol);
      end
   endtask

   // Offers an angle and returns just after the edge that transfers it.
   // The angle bus is then scrambled to show that later changes are ignored.
   task automatic applyStimulus(input int angle);
      int n;
      @(negedge clk);
      io.in_valid = 1'b1;
      io.angle    = WIDTH'(angle);
      #1;
      n = 0;
      while (!io.in_ready && n < 50) begin
         @(negedge clk);
         #1;
         n++;
      end
      if (!io.in_ready) checkOutput("accept timeout", 0, 1, 0);
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
      io.angle    = WIDTH'(22'h2A5A5);
   endtask

   // Counts clocks, including the transfer edge, until out_valid is seen.
   task automatic waitResult(output int lat);
      lat = 1;
      @(negedge clk);
      while (!io.out_valid && lat < 200) begin
         @(negedge clk);
         lat++;
      end
   endtask

   // Full single operation with out_ready held high.
   task automatic runOne(input string tag, input int angle,
                         input int expCos, input int expSin);
      int lat;
      applyStimulus(angle);
      waitResult(lat);
      checkOutput({tag, " latency"}, lat, LAT, 0);
      checkOutput({tag, " out_valid"}, int'(io.out_valid), 1, 0);
      checkOutput({tag, " cos"}, int'(io.cos_out), expCos, TOL);
      checkOutput({tag, " sin"}, int'(io.sin_out), expSin, TOL);
      @(negedge clk);
      checkOutput({tag, " valid drop"}, int'(io.out_valid), 0, 0);
   endtask

   function automatic int refCos(input int angle);
      return int'($cos(real'(angle) / SCALE) * SCALE);
   endfunction

   function automatic int refSin(input int angle);
      return int'($sin(real'(angle) / SCALE) * SCALE);
   endfunction

   initial begin
      int lat;
      int angles[$];
      int pending[$];
      int cyc;
      int k;
      int got;
      int lastOut;
      int a;

      io.in_valid  = 1'b0;
      io.angle     = '0;
      io.out_ready = 1'b1;

      // Reset state.
      #12;
      checkOutput("reset out_valid", int'(io.out_valid), 0, 0);
      checkOutput("reset in_ready", int'(io.in_ready), 0, 0);
      checkOutput("reset cos", int'(io.cos_out), 0, 0);
      checkOutput("reset sin", int'(io.sin_out), 0, 0);
      @(negedge clk);
      reset_n = 1'b1;
      #1;
      checkOutput("idle in_ready", int'(io.in_ready), 1, 0);

      // Directed angles.
      runOne("zero", 0, 524288, 0);
      runOne("pi/6", 274517, 454047, 262144);
      runOne("-pi/4", -411775, 370728, -370728);

      // Backpressure: result must hold for 10 cycles with in_ready low.
      io.out_ready = 1'b0;
      applyStimulus(274517);
      waitResult(lat);
      checkOutput("bp latency", lat, LAT, 0);
      for (int c = 0; c < 10; c++) begin
         checkOutput("bp out_valid", int'(io.out_valid), 1, 0);
         checkOutput("bp in_ready", int'(io.in_ready), 0, 0);
         checkOutput("bp cos", int'(io.cos_out), 454047, TOL);
         checkOutput("bp sin", int'(io.sin_out), 262144, TOL);
         @(negedge clk);
      end
      // Release together with a new angle: accepted in the same cycle.
      io.out_ready = 1'b1;
      io.in_valid  = 1'b1;
      io.angle     = WIDTH'(-411775);
      #1;
      checkOutput("bp release in_ready", int'(io.in_ready), 1, 0);
      @(posedge clk);
      #1;
      io.in_valid = 1'b0;
      waitResult(lat);
      checkOutput("bp next latency", lat, LAT, 0);
      checkOutput("bp next cos", int'(io.cos_out), 370728, TOL);
      checkOutput("bp next sin", int'(io.sin_out), -370728, TOL);
      @(negedge clk);

      // Reset in the middle of an operation.
      applyStimulus(274517);
      repeat (8) @(posedge clk);
      @(negedge clk);
      reset_n = 1'b0;
      #1;
      checkOutput("midrst out_valid", int'(io.out_valid), 0, 0);
      checkOutput("midrst in_ready", int'(io.in_ready), 0, 0);
      checkOutput("midrst cos", int'(io.cos_out), 0, 0);
      checkOutput("midrst sin", int'(io.sin_out), 0, 0);
      repeat (20) begin
         @(negedge clk);
         checkOutput("midrst no pulse", int'(io.out_valid), 0, 0);
      end
      reset_n = 1'b1;
      #1;
      checkOutput("midrst idle", int'(io.in_ready), 1, 0);
      runOne("post-reset zero", 0, 524288, 0);

      // Back-to-back stream of random angles within +/-pi/2.
      for (int r = 0; r < 100; r++)
         angles.push_back(int'($urandom_range(1647100, 0)) - 823550);
      io.out_ready = 1'b1;
      cyc     = 0;
      k       = 0;
      got     = 0;
      lastOut = -1;
      while (got < 100 && cyc < 3000) begin
         @(negedge clk);
         cyc++;
         io.in_valid = (k < 100);
         io.angle    = (k < 100) ? WIDTH'(angles[k]) : '0;
         #1;
         if (io.out_valid) begin
            if (pending.size() == 0) begin
               checkOutput("b2b spurious", 1, 0, 0);
            end else begin
               a = pending.pop_front();
               checkOutput("b2b cos", int'(io.cos_out), refCos(a), RTOL);
               checkOutput("b2b sin", int'(io.sin_out), refSin(a), RTOL);
            end
            if (lastOut >= 0) checkOutput("b2b period", cyc - lastOut, LAT, 0);
            lastOut = cyc;
            got++;
         end
         if (io.in_valid && io.in_ready) begin
            pending.push_back(angles[k]);
            k++;
         end
      end
      checkOutput("b2b count", got, 100, 0);
      @(negedge clk);
      io.in_valid = 1'b0;
      repeat (2) @(negedge clk);

`ifdef QUAD_EXT_EN
      // Extended quadrant range.
      runOne("pi", 1647099, -524288, 0);
      runOne("-3pi/4", -1235324, -370728, -370728);
`endif

      $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
      $finish;
   end

endmodule
